dma_transfer_engine: RTL and testbench

//  Bus-side DMA controller that consumes the CPU's DMA command word, written to CMD_ADDR.
//  On a command it takes the shared address/data bus by raising ADE, copies LEN words

---
 rtl/dma_transfer_engine.sv | 130 +++++++++++++
 tb/tb_dma_transfer_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_engine.sv
// ============================================================================
// dma_transfer_engine: bus-side DMA that copies LEN words SRC->DST on command
// Rev 1.0
// ============================================================================
`default_nettype none

module dma_transfer_engine #(
  parameter logic [31:0] CMD_ADDR = 32'd5000
) (
  input  logic        CLK,
  input  logic        RST_N,
  inout  wire  [31:0] address_Bus,
  inout  wire  [31:0] Data_Bus,
  input  logic        Read,
  input  logic        Write,
  output logic        ADE,
  output logic        DMA_Read,
  output logic        DMA_Write,
  output logic        BUSY,
  output logic        DMA_Done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t      state_q;
  logic        armed_q;
  logic        ade_q, rd_q, wr_q, busy_q, done_q;
  logic        addr_oe_q;
  logic [9:0]  addr_q;
  logic [9:0]  src_q, dst_q;
  logic [5:0]  len_q, idx_q;
  logic [5:0]  idx_d;
  logic [31:0] hold_q;
  logic        cmd_hit;

  // Only an idle bus with no CPU strobe at the command address counts as a command.
  assign cmd_hit = !ade_q && (address_Bus == CMD_ADDR) && !Read && !Write;
  assign idx_d   = idx_q + 6'd1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      ade_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_oe_q <= 1'b0;
      addr_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_hit && armed_q) begin
            armed_q <= 1'b0;
            if (Data_Bus[5:0] == 6'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_GRANT;
              ade_q   <= 1'b1;
              busy_q  <= 1'b1;
              src_q   <= Data_Bus[25:16];
              dst_q   <= Data_Bus[15:6];
              len_q   <= Data_Bus[5:0];
              idx_q   <= '0;
            end
          end else if (!cmd_hit) begin
            armed_q <= 1'b1;
          end
        end
        S_GRANT: begin
          state_q   <= S_READ;
          rd_q      <= 1'b1;
          addr_oe_q <= 1'b1;
          addr_q    <= src_q + {4'd0, idx_q};
        end
        S_READ: begin
          state_q <= S_WRITE;
          hold_q  <= Data_Bus;
          rd_q    <= 1'b0;
          wr_q    <= 1'b1;
          addr_q  <= dst_q + {4'd0, idx_q};
        end
        S_WRITE: begin
          wr_q  <= 1'b0;
          idx_q <= idx_d;
          if (idx_d == len_q) begin
            state_q   <= S_RELEASE;
            addr_oe_q <= 1'b0;
          end else begin
            state_q <= S_READ;
            rd_q    <= 1'b1;
            addr_q  <= src_q + {4'd0, idx_d};
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
          ade_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address_Bus = addr_oe_q ? {22'd0, addr_q} : 32'hzzzz_zzzz;
  assign Data_Bus    = wr_q ? hold_q : 32'hzzzz_zzzz;

  assign ADE       = ade_q;
  assign DMA_Read  = rd_q;
  assign DMA_Write = wr_q;
  assign BUSY      = busy_q;
  assign DMA_Done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_transfer_engine.sv
// ============================================================================
// tb_dma_transfer_engine: scoreboard bench with CPU, memory and copy model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dma_transfer_engine;

  localparam logic [31:0] CMD = 32'd5000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cpu_drive = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_data = 32'h0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  wire  [31:0] address_Bus;
  wire  [31:0] Data_Bus;
  logic        ADE, DMA_Read, DMA_Write, BUSY, DMA_Done;

  logic [31:0] mem [1024];
  logic [31:0] model_mem [1024];

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } op_t;
  op_t sbq[$];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_transfer_engine #(.CMD_ADDR(CMD)) dut (
    .CLK(CLK), .RST_N(RST_N), .address_Bus(address_Bus), .Data_Bus(Data_Bus),
    .Read(cpu_rd), .Write(cpu_wr), .ADE(ADE), .DMA_Read(DMA_Read),
    .DMA_Write(DMA_Write), .BUSY(BUSY), .DMA_Done(DMA_Done)
  );

  // CPU backs off the buses whenever the DMA holds the grant
  assign address_Bus = (cpu_drive && !ADE) ? cpu_addr : 32'hzzzz_zzzz;
  assign Data_Bus    = (cpu_drive && !ADE) ? cpu_data : 32'hzzzz_zzzz;
  assign Data_Bus    = (ADE && DMA_Read) ? mem[address_Bus[9:0]] : 32'hzzzz_zzzz;

  always @(posedge CLK)
    if (ADE && DMA_Write) mem[address_Bus[9:0]] <= Data_Bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Word-by-word copy in ascending order, exactly as a CPU memcpy would do it
  task automatic model_copy(input logic [9:0] src, input logic [9:0] dst, input int n);
    logic [9:0]  ra, wa;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      ra = src + 10'(i);
      wa = dst + 10'(i);
      d  = model_mem[ra];
      sbq.push_back('{wr: 1'b0, addr: ra, data: d});
      model_mem[wa] = d;
      sbq.push_back('{wr: 1'b1, addr: wa, data: d});
    end
  endtask

  function automatic logic [31:0] mk(input logic [9:0] s, input logic [9:0] d, input logic [5:0] l);
    logic [5:0] top;
    top = 6'($urandom);
    return {top, s, d, l};
  endfunction

  always @(negedge CLK) begin
    op_t e;
    if (DMA_Read || DMA_Write) begin
      chk("strobe_exclusive", {31'd0, DMA_Read & DMA_Write}, 32'd0);
      chk("strobe_needs_ade", {31'd0, ADE}, 32'd1);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe rd=%0b wr=%0b addr=%h", DMA_Read, DMA_Write, address_Bus);
      end else begin
        e = sbq.pop_front();
        chk("op_kind", {31'd0, DMA_Write}, {31'd0, e.wr});
        chk("op_addr", address_Bus, {22'd0, e.addr});
        if (e.wr) chk("op_data", Data_Bus, e.data);
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 after the done pulse.
  task automatic run_cmd(input logic [31:0] word, input bit rearm, input string tag);
    int len, k;
    len = int'(word[5:0]);
    if (rearm) begin
      cpu_addr = 32'h4;
      @(posedge CLK); #1;
    end
    cpu_drive = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = CMD; cpu_data = word;
    model_copy(word[25:16], word[15:6], len);
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_ade_after_accept"}, {31'd0, ADE}, {31'd0, len != 0});
    chk({tag, "_busy_after_accept"}, {31'd0, BUSY}, {31'd0, len != 0});
    k = 0;
    while (!DMA_Done && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk({tag, "_done_latency"}, k, (len == 0) ? 0 : 2 * len + 2);
    chk({tag, "_ade_at_done"}, {31'd0, ADE}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
    chk({tag, "_scoreboard_drained"}, sbq.size(), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int bad;
    logic [31:0] w;
    logic [9:0] s, d;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    mem[16] = 32'hAAAA_0001; mem[17] = 32'hBBBB_0002; mem[18] = 32'hCCCC_0003;
    for (int i = 16; i < 19; i++) model_mem[i] = mem[i];

    // Reset: CPU drives known values to show the DMA leaves both buses free
    cpu_drive = 1'b1; cpu_addr = 32'h123; cpu_data = 32'h5A5A_0F0F;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ade", {31'd0, ADE}, 32'd0);
    chk("rst_dma_read", {31'd0, DMA_Read}, 32'd0);
    chk("rst_dma_write", {31'd0, DMA_Write}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DMA_Done}, 32'd0);
    chk("rst_addr_bus_free", address_Bus, 32'h123);
    chk("rst_data_bus_free", Data_Bus, 32'h5A5A_0F0F);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    run_cmd(32'h0010_0803, 1'b1, "basic");
    chk("basic_mem20", mem[32], 32'hAAAA_0001);
    chk("basic_mem21", mem[33], 32'hBBBB_0002);
    chk("basic_mem22", mem[34], 32'hCCCC_0003);

    // Held command address must not retrigger
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ADE || BUSY || DMA_Done) bad++;
    end
    chk("hold_no_retrigger", bad, 32'd0);
    @(posedge CLK); #1;
    run_cmd(32'h0010_0803, 1'b1, "repeat");

    run_cmd(mk(10'h055, 10'h066, 6'd0), 1'b1, "len0");
    run_cmd(mk(10'h3FF, 10'h100, 6'd2), 1'b1, "wrap");

    // Strobed CPU accesses at the command address are not commands
    cpu_addr = 32'h4;
    @(posedge CLK); #1;
    cpu_addr = CMD; cpu_data = mk(10'h001, 10'h002, 6'd3);
    bad = 0;
    cpu_rd = 1'b1;
    repeat (3) begin @(negedge CLK); if (ADE || BUSY || DMA_Done) bad++; end
    @(posedge CLK); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b1;
    repeat (3) begin @(negedge CLK); if (ADE || BUSY || DMA_Done) bad++; end
    chk("strobed_no_accept", bad, 32'd0);
    @(posedge CLK); #1;
    cpu_wr = 1'b0; cpu_addr = 32'h4;
    @(posedge CLK); #1;

    // Abort during the second READ of a 4-word copy
    s = 10'h200; d = 10'h280;
    cpu_addr = CMD; cpu_data = mk(s, d, 6'd4);
    model_copy(s, d, 1);
    sbq.push_back('{wr: 1'b0, addr: s + 10'd1, data: model_mem[s + 10'd1]});
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_ade", {31'd0, ADE}, 32'd0);
    chk("abort_strobes", {30'd0, DMA_Read, DMA_Write}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_scoreboard", sbq.size(), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_cmd(mk(10'h300, 10'h310, 6'd2), 1'b0, "post_reset");

    for (int t = 0; t < 8; t++) begin
      s = 10'($urandom); d = 10'($urandom);
      w = mk(s, d, (t == 7) ? 6'd63 : 6'($urandom_range(1, 12)));
      run_cmd(w, 1'b1, "rand");
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== model_mem[i]) bad++;
    chk("mem_image", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
